// File: rtl/base_sys_timer_pkg.sv
// Shared definitions for the interval-timer scheduler: register map, control bits, FSM encoding.
package base_sys_timer_pkg;

   localparam int unsigned AVM_ADDR_W   = 3;
   localparam int unsigned AVM_DATA_W   = 16;
   localparam int unsigned TMR_PERIOD_W = 32;

   // Interval timer register map
   localparam logic [AVM_ADDR_W-1:0] REG_STATUS   = 3'd0;
   localparam logic [AVM_ADDR_W-1:0] REG_CONTROL  = 3'd1;
   localparam logic [AVM_ADDR_W-1:0] REG_PERIOD_L = 3'd2;
   localparam logic [AVM_ADDR_W-1:0] REG_PERIOD_H = 3'd3;
   localparam logic [AVM_ADDR_W-1:0] REG_SNAP_L   = 3'd4;
   localparam logic [AVM_ADDR_W-1:0] REG_SNAP_H   = 3'd5;

   // Control register bit positions
   localparam int unsigned CTRL_ITO   = 0;
   localparam int unsigned CTRL_CONT  = 1;
   localparam int unsigned CTRL_START = 2;
   localparam int unsigned CTRL_STOP  = 3;

   // One-shot start with irq enabled, and a plain stop with irq disabled
   localparam logic [AVM_DATA_W-1:0] CTRL_ONESHOT = AVM_DATA_W'((1 << CTRL_START) | (1 << CTRL_ITO));
   localparam logic [AVM_DATA_W-1:0] CTRL_HALT    = AVM_DATA_W'(1 << CTRL_STOP);
   localparam logic [AVM_DATA_W-1:0] STATUS_CLEAR = '0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_PL,
      ST_WR_PH,
      ST_WR_CTRL,
      ST_WAIT_IRQ,
      ST_CLR_DONE,
      ST_STOP,
      ST_CLR_ABT
   } sched_state_e;

   // A zero period would never expire meaningfully; run it as one tick instead
   function automatic logic [TMR_PERIOD_W-1:0] clamp_period(input logic [TMR_PERIOD_W-1:0] p);
      return (p == '0) ? TMR_PERIOD_W'(1) : p;
   endfunction

endpackage

// File: rtl/base_sys_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after the pointer wins.
module base_sys_rr_arbiter
#(
   parameter  int unsigned N_REQ = 4,
   localparam int unsigned IDX_W = $clog2(N_REQ)
)
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] pointer,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] index,
   output logic             any
);

   localparam int N = int'(N_REQ);

   // Scan from farthest to nearest offset so the nearest requester overrides
   always_comb begin
      int             cand;
      logic [IDX_W-1:0] cand_idx;
      grant    = '0;
      index    = '0;
      any      = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int off = N; off >= 1; off--) begin
         cand = int'(pointer) + off;
         if (cand >= N) cand = cand - N;
         cand_idx = IDX_W'(cand);
         if (req[cand_idx]) begin
            grant           = '0;
            grant[cand_idx] = 1'b1;
            index           = cand_idx;
            any             = 1'b1;
         end
      end
   end

endmodule

// File: rtl/base_sys_timer_sched.sv
// Shares one interval timer among N_REQ one-shot delay requesters.
module base_sys_timer_sched
   import base_sys_timer_pkg::*;
#(
   parameter  int unsigned N_REQ    = 4,
   parameter  int unsigned PERIOD_W = 32,
   localparam int unsigned IDX_W    = $clog2(N_REQ)
)
(
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*PERIOD_W-1:0] req_period,
   input  logic [N_REQ-1:0]          cancel,
   output logic [N_REQ-1:0]          done,
   output logic [N_REQ-1:0]          aborted,
   output logic                      busy,
   output logic [IDX_W-1:0]          grant_id,
   output logic [2:0]                avm_address,
   output logic                      avm_chipselect,
   output logic                      avm_write_n,
   output logic [15:0]               avm_writedata,
   input  logic                      timer_irq
);

   sched_state_e            state_q;
   logic [IDX_W-1:0]        ptr_q;
   logic [IDX_W-1:0]        grant_q;
   logic [15:0]             period_hi_q;
   logic                    cancel_pend_q;
   logic [N_REQ-1:0]        done_q;
   logic [N_REQ-1:0]        aborted_q;
   logic                    busy_q;
   logic [AVM_ADDR_W-1:0]   avm_address_q;
   logic                    avm_chipselect_q;
   logic                    avm_write_n_q;
   logic [AVM_DATA_W-1:0]   avm_writedata_q;

   logic [N_REQ-1:0]        arb_grant;
   logic [IDX_W-1:0]        arb_index;
   logic                    arb_any;
   logic [PERIOD_W-1:0]     period_sel;
   logic [TMR_PERIOD_W-1:0] period_new;
   logic                    cancel_grant;

   base_sys_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req     (req),
      .pointer (ptr_q),
      .grant   (arb_grant),
      .index   (arb_index),
      .any     (arb_any)
   );

   // Period of the requester the arbiter is about to pick
   always_comb begin
      period_sel = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (arb_grant[i]) period_sel = req_period[i*int'(PERIOD_W) +: PERIOD_W];
      end
   end

   assign period_new   = clamp_period(period_sel);
   assign cancel_grant = cancel[grant_q];

   // Scheduler FSM; bus strobes are registered together with the state they belong to
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         ptr_q            <= IDX_W'(N_REQ - 1);
         grant_q          <= '0;
         period_hi_q      <= '0;
         cancel_pend_q    <= 1'b0;
         done_q           <= '0;
         aborted_q        <= '0;
         busy_q           <= 1'b0;
         avm_address_q    <= '0;
         avm_chipselect_q <= 1'b0;
         avm_write_n_q    <= 1'b1;
         avm_writedata_q  <= '0;
      end else begin
         done_q           <= '0;
         aborted_q        <= '0;
         avm_address_q    <= '0;
         avm_chipselect_q <= 1'b0;
         avm_write_n_q    <= 1'b1;
         avm_writedata_q  <= '0;
         case (state_q)
            ST_IDLE: begin
               if (arb_any) begin
                  state_q          <= ST_WR_PL;
                  grant_q          <= arb_index;
                  ptr_q            <= arb_index;
                  period_hi_q      <= period_new[31:16];
                  cancel_pend_q    <= 1'b0;
                  busy_q           <= 1'b1;
                  avm_address_q    <= REG_PERIOD_L;
                  avm_chipselect_q <= 1'b1;
                  avm_write_n_q    <= 1'b0;
                  avm_writedata_q  <= period_new[15:0];
               end
            end
            ST_WR_PL: begin
               state_q          <= ST_WR_PH;
               cancel_pend_q    <= cancel_pend_q | cancel_grant;
               avm_address_q    <= REG_PERIOD_H;
               avm_chipselect_q <= 1'b1;
               avm_write_n_q    <= 1'b0;
               avm_writedata_q  <= period_hi_q;
            end
            ST_WR_PH: begin
               state_q          <= ST_WR_CTRL;
               cancel_pend_q    <= cancel_pend_q | cancel_grant;
               avm_address_q    <= REG_CONTROL;
               avm_chipselect_q <= 1'b1;
               avm_write_n_q    <= 1'b0;
               avm_writedata_q  <= CTRL_ONESHOT;
            end
            ST_WR_CTRL: begin
               state_q       <= ST_WAIT_IRQ;
               cancel_pend_q <= cancel_pend_q | cancel_grant;
            end
            ST_WAIT_IRQ: begin
               // A timeout already delivered takes precedence over a late cancel
               if (timer_irq) begin
                  state_q          <= ST_CLR_DONE;
                  avm_address_q    <= REG_STATUS;
                  avm_chipselect_q <= 1'b1;
                  avm_write_n_q    <= 1'b0;
                  avm_writedata_q  <= STATUS_CLEAR;
               end else if (cancel_grant || cancel_pend_q) begin
                  state_q          <= ST_STOP;
                  avm_address_q    <= REG_CONTROL;
                  avm_chipselect_q <= 1'b1;
                  avm_write_n_q    <= 1'b0;
                  avm_writedata_q  <= CTRL_HALT;
               end
            end
            ST_CLR_DONE: begin
               state_q          <= ST_IDLE;
               busy_q           <= 1'b0;
               done_q[grant_q]  <= 1'b1;
            end
            ST_STOP: begin
               state_q          <= ST_CLR_ABT;
               avm_address_q    <= REG_STATUS;
               avm_chipselect_q <= 1'b1;
               avm_write_n_q    <= 1'b0;
               avm_writedata_q  <= STATUS_CLEAR;
            end
            ST_CLR_ABT: begin
               state_q            <= ST_IDLE;
               busy_q             <= 1'b0;
               aborted_q[grant_q] <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign done           = done_q;
   assign aborted        = aborted_q;
   assign busy           = busy_q;
   assign grant_id       = grant_q;
   assign avm_address    = avm_address_q;
   assign avm_chipselect = avm_chipselect_q;
   assign avm_write_n    = avm_write_n_q;
   assign avm_writedata  = avm_writedata_q;

endmodule
